// File: rtl/ps2_key_scheduler.sv
// Frame-paced PS/2 keycode scheduler and gamepad arbiter for the Gigatron IN port.
// Define PS2_SCHED_FIFO_EN for a circular-buffer queue; otherwise one holding register.
module ps2_key_scheduler #(
   parameter int HOLD_FRAMES     = 2,
   parameter int GAP_FRAMES      = 1,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic [7:0] ps2_data,
   input  logic       ps2_ready,
   output logic       ps2_sending,
   input  logic [7:0] pad_data,
   input  logic       vsync_n,
   output logic [7:0] in_data,
   output logic [7:0] drop_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

   localparam logic [3:0] HOLD_N = 4'(HOLD_FRAMES);
   localparam logic [3:0] GAP_N  = 4'(GAP_FRAMES);

   logic       rdy_q;
   logic [7:0] last_q;
   logic       send_q;
   logic [7:0] drop_q;
   logic       cap;
   logic       push;
   logic       pop;
   logic       full;
   logic       empty;
   logic [7:0] head;

   assign cap = ps2_ready && ps2_data != 8'hFF
             && (!rdy_q || ps2_data != last_q);
   // A pop on the same cycle frees a slot, so a full queue still accepts
   assign push = cap && (!full || pop);

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         rdy_q  <= 1'b0;
         last_q <= 8'hFF;
         send_q <= 1'b0;
         drop_q <= 8'h00;
      end else begin
         rdy_q  <= ps2_ready;
         send_q <= cap;
         if (cap)
            last_q <= ps2_data;
         if (cap && !push && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
      end
   end

`ifdef PS2_SCHED_FIFO_EN
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2-1:0] P_ONE = 1;
   localparam logic [FIFO_DEPTH_LOG2:0]   C_ONE = 1;
   localparam logic [FIFO_DEPTH_LOG2:0]   C_MAX = DEPTH;

   logic [7:0]                 mem_q [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wptr_q;
   logic [FIFO_DEPTH_LOG2-1:0] rptr_q;
   logic [FIFO_DEPTH_LOG2:0]   cnt_q;

   assign full  = cnt_q == C_MAX;
   assign empty = cnt_q == '0;
   assign head  = mem_q[rptr_q];

   always_ff @(posedge CLOCK_50) begin
      if (push)
         mem_q[wptr_q] <= ps2_data;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push)
            wptr_q <= wptr_q + P_ONE;
         if (pop)
            rptr_q <= rptr_q + P_ONE;
         if (push && !pop)
            cnt_q <= cnt_q + C_ONE;
         else if (pop && !push)
            cnt_q <= cnt_q - C_ONE;
      end
   end
`else
   localparam int unused_depth_log2 = FIFO_DEPTH_LOG2;

   logic [7:0] hold_q;
   logic       valid_q;

   assign full  = valid_q;
   assign empty = !valid_q;
   assign head  = hold_q;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         hold_q  <= 8'hFF;
         valid_q <= 1'b0;
      end else if (push) begin
         hold_q  <= ps2_data;
         valid_q <= 1'b1;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end
`endif

   logic s1_q;
   logic s2_q;
   logic s3_q;
   logic tick;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= vsync_n;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign tick = s3_q && !s2_q;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] frm_q;
   logic [3:0] frm_d;
   logic [7:0] key_q;
   logic [7:0] in_q;
   logic [7:0] in_d;
   logic       pad_act;
   logic       go;

   assign pad_act = pad_data != 8'hFF;
   assign go      = tick && !pad_act;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         frm_q   <= 4'd0;
         key_q   <= 8'hFF;
         in_q    <= 8'hFF;
      end else begin
         state_q <= state_d;
         frm_q   <= frm_d;
         in_q    <= in_d;
         if (pop)
            key_q <= head;
      end
   end

   always_comb begin
      state_d = state_q;
      frm_d   = frm_q;
      if (go) begin
         unique case (state_q)
            S_HOLD: begin
               if (frm_q < HOLD_N) begin
                  frm_d = frm_q + 4'd1;
               end else begin
                  state_d = S_GAP;
                  frm_d   = 4'd1;
               end
            end
            S_GAP: begin
               // Gap ending falls straight into the idle rule
               if (frm_q < GAP_N) begin
                  frm_d = frm_q + 4'd1;
               end else if (!empty) begin
                  state_d = S_HOLD;
                  frm_d   = 4'd1;
               end else begin
                  state_d = S_IDLE;
                  frm_d   = 4'd0;
               end
            end
            default: begin
               if (!empty) begin
                  state_d = S_HOLD;
                  frm_d   = 4'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      pop  = 1'b0;
      in_d = in_q;
      if (tick && pad_act) begin
         in_d = pad_data;
      end else if (go) begin
         pop = state_d == S_HOLD && state_q != S_HOLD;
         if (pop)
            in_d = head;
         else if (state_d == S_HOLD)
            in_d = key_q;
         else
            in_d = 8'hFF;
      end
   end

   assign ps2_sending = send_q;
   assign in_data     = in_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Directed bench for ps2_key_scheduler: vector table of resets, keys and
// frames, then hand sequences for capture rules, saturation and async reset.
module tb_ps2_key_scheduler;

   logic       clk;
   logic       rst_n;
   logic [7:0] ps2_data;
   logic       ps2_ready;
   logic       ps2_sending;
   logic [7:0] pad_data;
   logic       vsync_n;
   logic [7:0] in_data;
   logic [7:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   localparam int OP_RST  = 0;
   localparam int OP_KEY  = 1;
   localparam int OP_FRM  = 2;
   localparam int OP_DROP = 3;

   typedef struct {
      int         op;
      logic [7:0] a;
      logic [7:0] b;
   } vec_t;

   vec_t vecs[$];

   ps2_key_scheduler dut (
      .CLOCK_50    (clk),
      .reset_n     (rst_n),
      .ps2_data    (ps2_data),
      .ps2_ready   (ps2_ready),
      .ps2_sending (ps2_sending),
      .pad_data    (pad_data),
      .vsync_n     (vsync_n),
      .in_data     (in_data),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic void add(input int op,
                               input logic [7:0] a,
                               input logic [7:0] b);
      vecs.push_back('{op, a, b});
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      ps2_ready = 1'b0;
      ps2_data  = 8'h00;
      pad_data  = 8'hFF;
      vsync_n   = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst in_data", in_data, 8'hFF);
      chk("rst drop_cnt", drop_cnt, 8'h00);
      chk("rst sending", {7'd0, ps2_sending}, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_key(input logic [7:0] k);
      ps2_data  = k;
      ps2_ready = 1'b1;
      @(negedge clk);
      chk("key pulse", {7'd0, ps2_sending}, 8'h01);
      ps2_ready = 1'b0;
      @(negedge clk);
      chk("key pulse end", {7'd0, ps2_sending}, 8'h00);
   endtask

   task automatic do_frame(input logic [7:0] pad,
                           input logic [7:0] exp);
      int sends;
      sends    = 0;
      pad_data = pad;
      vsync_n  = 1'b0;
      repeat (4) begin
         @(negedge clk);
         sends += int'(ps2_sending);
      end
      vsync_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         sends += int'(ps2_sending);
      end
      chk("frame in_data", in_data, exp);
      chk("frame no send", 8'(sends), 8'h00);
   endtask

   initial begin
      int sends;
      rst_n     = 1'b1;
      ps2_ready = 1'b0;
      ps2_data  = 8'h00;
      pad_data  = 8'hFF;
      vsync_n   = 1'b1;

      // idle, no keys
      add(OP_RST, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++)
         add(OP_FRM, 8'hFF, 8'hFF);

      // single key, default pacing
      add(OP_RST, 8'h00, 8'h00);
      add(OP_KEY, 8'h61, 8'h00);
      add(OP_FRM, 8'hFF, 8'h61);
      add(OP_FRM, 8'hFF, 8'h61);
      add(OP_FRM, 8'hFF, 8'hFF);
      add(OP_FRM, 8'hFF, 8'hFF);
      add(OP_DROP, 8'h00, 8'h00);

      // three keys in one frame
      add(OP_RST, 8'h00, 8'h00);
      add(OP_KEY, 8'h31, 8'h00);
      add(OP_KEY, 8'h32, 8'h00);
      add(OP_KEY, 8'h33, 8'h00);
`ifdef PS2_SCHED_FIFO_EN
      for (int i = 0; i < 3; i++) begin
         add(OP_FRM, 8'hFF, 8'(8'h31 + i));
         add(OP_FRM, 8'hFF, 8'(8'h31 + i));
         add(OP_FRM, 8'hFF, 8'hFF);
      end
      add(OP_FRM, 8'hFF, 8'hFF);
      add(OP_DROP, 8'h00, 8'h00);
`else
      add(OP_FRM, 8'hFF, 8'h31);
      add(OP_FRM, 8'hFF, 8'h31);
      add(OP_FRM, 8'hFF, 8'hFF);
      add(OP_FRM, 8'hFF, 8'hFF);
      add(OP_DROP, 8'h00, 8'h02);
`endif

      // pad preempts mid-hold
      add(OP_RST, 8'h00, 8'h00);
      add(OP_KEY, 8'h41, 8'h00);
      add(OP_FRM, 8'hFF, 8'h41);
      add(OP_FRM, 8'hFE, 8'hFE);
      add(OP_FRM, 8'hFE, 8'hFE);
      add(OP_FRM, 8'hFF, 8'h41);
      add(OP_FRM, 8'hFF, 8'hFF);
      add(OP_FRM, 8'hFF, 8'hFF);

      // pad in idle blocks the pop
      add(OP_RST, 8'h00, 8'h00);
      add(OP_KEY, 8'h70, 8'h00);
      add(OP_FRM, 8'hFD, 8'hFD);
      add(OP_FRM, 8'hFF, 8'h70);
      add(OP_FRM, 8'hFF, 8'h70);
      add(OP_FRM, 8'hFF, 8'hFF);

      // six keys, overflow
      add(OP_RST, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++)
         add(OP_KEY, 8'(8'h51 + i), 8'h00);
`ifdef PS2_SCHED_FIFO_EN
      add(OP_DROP, 8'h00, 8'h02);
      for (int i = 0; i < 4; i++) begin
         add(OP_FRM, 8'hFF, 8'(8'h51 + i));
         add(OP_FRM, 8'hFF, 8'(8'h51 + i));
         add(OP_FRM, 8'hFF, 8'hFF);
      end
      add(OP_FRM, 8'hFF, 8'hFF);
`else
      add(OP_DROP, 8'h00, 8'h05);
      add(OP_FRM, 8'hFF, 8'h51);
      add(OP_FRM, 8'hFF, 8'h51);
      add(OP_FRM, 8'hFF, 8'hFF);
      add(OP_FRM, 8'hFF, 8'hFF);
`endif

      foreach (vecs[i]) begin
         unique case (vecs[i].op)
            OP_RST:  do_reset();
            OP_KEY:  do_key(vecs[i].a);
            OP_FRM:  do_frame(vecs[i].a, vecs[i].b);
            default: chk("drop_cnt", drop_cnt, vecs[i].b);
         endcase
      end

      // ready held high: one pulse per new value, none for 0xFF
      do_reset();
      ps2_data  = 8'h1C;
      ps2_ready = 1'b1;
      sends = 0;
      repeat (4) begin
         @(negedge clk);
         sends += int'(ps2_sending);
      end
      chk("held same", 8'(sends), 8'h01);
      ps2_data = 8'h1D;
      sends = 0;
      repeat (4) begin
         @(negedge clk);
         sends += int'(ps2_sending);
      end
      chk("held change", 8'(sends), 8'h01);
      ps2_data = 8'hFF;
      sends = 0;
      repeat (4) begin
         @(negedge clk);
         sends += int'(ps2_sending);
      end
      chk("held ff", 8'(sends), 8'h00);
      ps2_ready = 1'b0;
`ifdef PS2_SCHED_FIFO_EN
      chk("held drop", drop_cnt, 8'h00);
      do_frame(8'hFF, 8'h1C);
      do_frame(8'hFF, 8'h1C);
      do_frame(8'hFF, 8'hFF);
      do_frame(8'hFF, 8'h1D);
`else
      chk("held drop", drop_cnt, 8'h01);
      do_frame(8'hFF, 8'h1C);
      do_frame(8'hFF, 8'h1C);
      do_frame(8'hFF, 8'hFF);
      do_frame(8'hFF, 8'hFF);
`endif

      // drop counter saturation
      do_reset();
      for (int i = 0; i < 300; i++) begin
         ps2_data  = 8'(8'h20 + (i % 64));
         ps2_ready = 1'b1;
         @(negedge clk);
         ps2_ready = 1'b0;
         @(negedge clk);
      end
      chk("drop sat", drop_cnt, 8'hFF);

      // asynchronous reset mid-hold
      do_reset();
      do_key(8'h55);
`ifdef PS2_SCHED_FIFO_EN
      do_key(8'h56);
`endif
      do_frame(8'hFF, 8'h55);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async in_data", in_data, 8'hFF);
      chk("async sending", {7'd0, ps2_sending}, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_frame(8'hFF, 8'hFF);
      do_frame(8'hFF, 8'hFF);
      chk("async drop", drop_cnt, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
